// File: rtl/pulso_pkg.sv
// Shared types and constants for the pulso_gen pulse/delay timer.
package pulso_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        PULSE = 2'd2
    } pulso_state_t;

    localparam logic PULSO_ONESHOT  = 1'b0;
    localparam logic PULSO_PERIODIC = 1'b1;

endpackage

// File: rtl/pulso_cnt.sv
// Up-counter with synchronous clear and enable, flagging equality with a limit.
module pulso_cnt import pulso_pkg::*; #(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic             hit
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit = (cnt_q == limit);

endmodule

// File: rtl/pulso_gen.sv
// Programmable delay-then-pulse timer with one-shot/periodic modes, retrigger and abort.
module pulso_gen import pulso_pkg::*; #(
    parameter int WIDTH     = 18,
    parameter int RETRIGGER = 1
) (
    input  logic             Clk,
    input  logic             Clr_n,
    input  logic             Start,
    input  logic             Stop,
    input  logic             Mode,
    input  logic [WIDTH-1:0] Delay,
    input  logic [WIDTH-1:0] Width,
    output logic             Mo,
    output logic             Busy,
    output logic             Done
);

    pulso_state_t     state_q, state_d;
    logic [WIDTH-1:0] delay_q, delay_d;
    logic [WIDTH-1:0] width_q, width_d;
    logic             mode_q, mode_d;
    logic             mo_q, mo_d, busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0] limit;
    logic             cnt_clr, cnt_en, cnt_hit;
    logic             start_ok, pulse_end;

    assign start_ok  = Start && ((state_q == IDLE) || (RETRIGGER != 0));
    assign pulse_end = (state_q == PULSE) && cnt_hit;
    // One counter serves both phases; width_q is never 0 so width_q-1 cannot underflow.
    assign limit     = (state_q == PULSE) ? (width_q - WIDTH'(1)) : delay_q;

    pulso_cnt #(.WIDTH(WIDTH)) u_cnt (
        .clk   (Clk),
        .rst_n (Clr_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .limit (limit),
        .hit   (cnt_hit)
    );

    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            state_q <= IDLE;
            delay_q <= '0;
            width_q <= '0;
            mode_q  <= PULSO_ONESHOT;
            mo_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            delay_q <= delay_d;
            width_q <= width_d;
            mode_q  <= mode_d;
            mo_q    <= mo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Stop outranks start/retrigger, which outranks normal sequencing.
    always_comb begin
        state_d = state_q;
        delay_d = delay_q;
        width_d = width_q;
        mode_d  = mode_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        if (Stop) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
        end else if (start_ok) begin
            state_d = DELAY;
            cnt_clr = 1'b1;
            delay_d = Delay;
            width_d = (Width == '0) ? WIDTH'(1) : Width;
            mode_d  = Mode;
        end else begin
            case (state_q)
                DELAY: begin
                    if (cnt_hit) begin
                        state_d = PULSE;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt_hit) begin
                        state_d = (mode_q == PULSO_PERIODIC) ? DELAY : IDLE;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mo_d   = (state_d == PULSE);
        busy_d = (state_d != IDLE);
        done_d = pulse_end && !Stop && !start_ok;
    end

    assign Mo   = mo_q;
    assign Busy = busy_q;
    assign Done = done_q;

endmodule

// File: tb/tb_pulso_gen.sv
// Randomised and directed checks of pulso_gen, with and without retrigger, against a timing model.
module tb_pulso_gen;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         clr_n = 1'b1;
    logic         start = 1'b0, stop = 1'b0, mode = 1'b0;
    logic [W-1:0] dly = '0, wid = '0;
    logic         mo1, busy1, done1, mo0, busy0, done0;

    int checks = 0;
    int errors = 0;

    // Model state, index 0 = no retrigger, 1 = retrigger.
    bit m_act[2];
    bit m_mode[2];
    int m_t0[2], m_d[2], m_w[2];
    bit e_mo[2], e_busy[2], e_done[2];
    int cyc = 0;

    always #5 clk = ~clk;

    pulso_gen #(.WIDTH(W), .RETRIGGER(1)) u_rt (
        .Clk(clk), .Clr_n(clr_n), .Start(start), .Stop(stop), .Mode(mode),
        .Delay(dly), .Width(wid), .Mo(mo1), .Busy(busy1), .Done(done1)
    );

    pulso_gen #(.WIDTH(W), .RETRIGGER(0)) u_nr (
        .Clk(clk), .Clr_n(clr_n), .Start(start), .Stop(stop), .Mode(mode),
        .Delay(dly), .Width(wid), .Mo(mo0), .Busy(busy0), .Done(done0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < 2; r++) begin
            m_act[r] = 0; e_mo[r] = 0; e_busy[r] = 0; e_done[r] = 0;
        end
    endtask

    // Outputs after edge cyc, from elapsed edges since the latching start.
    task automatic model_step(input int r);
        int k, p, q;
        if (stop) begin
            m_act[r] = 0; e_mo[r] = 0; e_busy[r] = 0; e_done[r] = 0;
        end else if (start && (!e_busy[r] || r == 1)) begin
            m_act[r] = 1; m_t0[r] = cyc; m_d[r] = int'(dly);
            m_w[r] = (wid == 0) ? 1 : int'(wid); m_mode[r] = mode;
            e_busy[r] = 1; e_mo[r] = 0; e_done[r] = 0;
        end else if (m_act[r]) begin
            k = cyc - m_t0[r];
            p = m_d[r] + 1 + m_w[r];
            q = m_mode[r] ? (k % p) : k;
            if (!m_mode[r] && k >= p) begin
                m_act[r] = 0; e_busy[r] = 0; e_mo[r] = 0; e_done[r] = (k == p);
            end else begin
                e_busy[r] = 1;
                e_mo[r]   = (q >= m_d[r] + 1) && (q <= m_d[r] + m_w[r]);
                e_done[r] = m_mode[r] && (q == 0) && (k > 0);
            end
        end else begin
            e_mo[r] = 0; e_busy[r] = 0; e_done[r] = 0;
        end
    endtask

    task automatic step(input bit st, input bit sp, input bit md,
                        input logic [W-1:0] d, input logic [W-1:0] w);
        @(negedge clk);
        start = st; stop = sp; mode = md; dly = d; wid = w;
        @(posedge clk);
        cyc++;
        model_step(0);
        model_step(1);
        #1;
        chk("mo_rt",   mo1,   e_mo[1]);
        chk("busy_rt", busy1, e_busy[1]);
        chk("done_rt", done1, e_done[1]);
        chk("mo_nr",   mo0,   e_mo[0]);
        chk("busy_nr", busy0, e_busy[0]);
        chk("done_nr", done0, e_done[0]);
    endtask

    initial begin
        logic [7:0] mo_h, busy_h, done_h;
        int rise_rt, rise_nr;

        // Reset state, asserted asynchronously
        #1 clr_n = 1'b0;
        #1;
        chk("rst_mo",   mo1,   0);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done0, 0);
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk) clr_n = 1'b1;
        step(0, 0, 0, 8'd0, 8'd0);

        // One-shot Delay=3 Width=2, histories after E0..E7
        mo_h = '0; busy_h = '0; done_h = '0;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) step(1, 0, 0, 8'd3, 8'd2);
            else        step(0, 0, 1, 8'd9, 8'd7);
            mo_h[i] = mo1; busy_h[i] = busy1; done_h[i] = done1;
        end
        chk("tp1_mo",   mo_h,   8'h30);
        chk("tp1_busy", busy_h, 8'h3f);
        chk("tp1_done", done_h, 8'h40);

        // Delay=0, Width=0
        mo_h = '0; done_h = '0;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) step(1, 0, 0, 8'd0, 8'd0);
            else        step(0, 0, 0, 8'd4, 8'd4);
            mo_h[i] = mo1; done_h[i] = done1;
        end
        chk("tp2_mo",   mo_h,   8'h02);
        chk("tp2_done", done_h, 8'h04);

        // Periodic Delay=2 Width=3 over 4 periods, then Stop mid-pulse
        step(1, 0, 1, 8'd2, 8'd3);
        mo_h = '0;
        for (int i = 1; i <= 28; i++) begin
            step(0, 0, 0, 8'd1, 8'd1);
            if (i < 7) mo_h[i] = mo1;
        end
        chk("tp3_mo", mo_h, 8'h38);
        chk("tp3_in_pulse", mo1, 1);
        step(0, 1, 0, 8'd0, 8'd0);
        chk("tp3_stop_busy", busy1, 0);
        step(0, 0, 0, 8'd0, 8'd0);

        // Retrigger: Delay=5, second Start at E3
        rise_rt = -1; rise_nr = -1;
        for (int i = 0; i < 14; i++) begin
            step((i == 0) || (i == 3), 0, 0, 8'd5, 8'd2);
            if (mo1 && rise_rt < 0) rise_rt = i;
            if (mo0 && rise_nr < 0) rise_nr = i;
        end
        chk("tp4_rise_rt", rise_rt, 9);
        chk("tp4_rise_nr", rise_nr, 6);

        // Start and Stop on the same edge
        step(1, 1, 0, 8'd1, 8'd1);
        chk("startstop_busy", busy1, 0);

        // Start on the final pulse edge of a one-shot (Delay=1 Width=2 ends at E4)
        for (int i = 0; i < 12; i++) step((i == 0) || (i == 4), 0, 0, 8'd1, 8'd2);

        // Asynchronous clear mid-pulse
        for (int i = 0; i < 4; i++) step(i == 0, 0, 0, 8'd1, 8'd5);
        chk("arst_pre_mo", mo1, 1);
        #2 clr_n = 1'b0;
        #1;
        chk("arst_mo",   mo1,   0);
        chk("arst_busy", busy1, 0);
        chk("arst_done", done1, 0);
        chk("arst_mo_nr", mo0,  0);
        model_clear();
        @(posedge clk);
        @(negedge clk) clr_n = 1'b1;
        for (int i = 0; i < 6; i++) step(0, 0, 0, 8'd0, 8'd0);

        // All-ones delay: no counter wrap, Mo rises after 2^W edges
        rise_rt = -1;
        for (int i = 0; i < 262; i++) begin
            step(i == 0, 0, 0, 8'hff, 8'd1);
            if (mo1 && rise_rt < 0) rise_rt = i;
        end
        chk("allones_rise", rise_rt, 256);

        // Randomised traffic, inputs wander every cycle
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 49) == 0) ? 8'hff : 8'($urandom_range(0, 6)),
                 8'($urandom_range(0, 4)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
